// File: rtl/fpu_mul_arbiter_if.sv
// Request/response channels for both requesters of fpu_mul_arbiter plus the busy flag.
interface fpu_mul_arbiter_if;
    logic [15:0] i_a0;
    logic [15:0] i_b0;
    logic        i_vld0;
    logic        o_rdy0;
    logic [15:0] o_res0;
    logic        o_res_vld0;
    logic        o_ovf0;
    logic        i_res_rdy0;
    logic [15:0] i_a1;
    logic [15:0] i_b1;
    logic        i_vld1;
    logic        o_rdy1;
    logic [15:0] o_res1;
    logic        o_res_vld1;
    logic        o_ovf1;
    logic        i_res_rdy1;
    logic        o_busy;

    modport slave (
        input  i_a0, i_b0, i_vld0, i_res_rdy0,
        input  i_a1, i_b1, i_vld1, i_res_rdy1,
        output o_rdy0, o_res0, o_res_vld0, o_ovf0,
        output o_rdy1, o_res1, o_res_vld1, o_ovf1,
        output o_busy
    );

    modport master (
        output i_a0, i_b0, i_vld0, i_res_rdy0,
        output i_a1, i_b1, i_vld1, i_res_rdy1,
        input  o_rdy0, o_res0, o_res_vld0, o_ovf0,
        input  o_rdy1, o_res1, o_res_vld1, o_ovf1,
        input  o_busy
    );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP16 multiplier between two requesters.
// Optional per-port overflow counters are built when FPU_MUL_STATS_EN is defined.

// FP16 multiply, round-to-nearest-even; subnormal inputs and results flush to signed zero.
module multiplier_fpu (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_vld,
    output logic [15:0] o_res,
    output logic        o_ovf
);
    logic              w_sign;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [21:0]       w_sig_a, w_sig_b, w_prod;
    logic [10:0]       w_mant;
    logic              w_guard, w_sticky;
    logic [11:0]       w_mant_rnd;
    logic signed [7:0] w_exp_pre, w_exp_post;

    // Operand classification, significand product, normalisation and rounding
    always_comb begin
        w_sign   = i_a[15] ^ i_b[15];
        w_a_nan  = (i_a[14:10] == 5'h1f) && (i_a[9:0] != 10'h000);
        w_b_nan  = (i_b[14:10] == 5'h1f) && (i_b[9:0] != 10'h000);
        w_a_inf  = (i_a[14:10] == 5'h1f) && (i_a[9:0] == 10'h000);
        w_b_inf  = (i_b[14:10] == 5'h1f) && (i_b[9:0] == 10'h000);
        w_a_zero = (i_a[14:10] == 5'h00);
        w_b_zero = (i_b[14:10] == 5'h00);
        w_sig_a  = {11'd0, 1'b1, i_a[9:0]};
        w_sig_b  = {11'd0, 1'b1, i_b[9:0]};
        w_prod   = w_sig_a * w_sig_b;
        if (w_prod[21]) begin
            w_mant   = w_prod[21:11];
            w_guard  = w_prod[10];
            w_sticky = |w_prod[9:0];
        end else begin
            w_mant   = w_prod[20:10];
            w_guard  = w_prod[9];
            w_sticky = |w_prod[8:0];
        end
        w_exp_pre  = $signed({3'b000, i_a[14:10]}) + $signed({3'b000, i_b[14:10]}) - 8'sd15
                   + (w_prod[21] ? 8'sd1 : 8'sd0);
        w_mant_rnd = {1'b0, w_mant} + {11'd0, w_guard & (w_sticky | w_mant[0])};
        w_exp_post = w_exp_pre + (w_mant_rnd[11] ? 8'sd1 : 8'sd0);

        o_res = 16'h0000;
        o_ovf = 1'b0;
        if (!i_vld) begin
            o_res = 16'h0000;
            o_ovf = 1'b0;
        end else if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            o_res = 16'h7e00;
            o_ovf = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            o_res = {w_sign, 15'h7c00};
            o_ovf = 1'b1;
        end else if (w_a_zero || w_b_zero || (w_exp_pre < 8'sd1)) begin
            o_res = {w_sign, 15'h0000};
            o_ovf = 1'b0;
        end else if (w_exp_post > 8'sd30) begin
            o_res = {w_sign, 15'h7c00};
            o_ovf = 1'b1;
        end else begin
            o_res = {w_sign, w_exp_post[4:0], (w_mant_rnd[11] ? w_mant_rnd[10:1] : w_mant_rnd[9:0])};
            o_ovf = 1'b0;
        end
    end
endmodule

module fpu_mul_arbiter #(
    parameter int RR_INIT = 0,
    parameter int STAT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fpu_mul_arbiter_if.slave    bus
`ifdef FPU_MUL_STATS_EN
    ,
    output logic [STAT_W-1:0]   o_ovf_cnt0,
    output logic [STAT_W-1:0]   o_ovf_cnt1
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic L_PRIO_INIT = (RR_INIT != 0);

    state_t      r_state, w_state_nxt;
    logic        r_prio, r_owner;
    logic [15:0] r_opa, r_opb;
    logic [15:0] r_res0, r_res1;
    logic        r_ovf0, r_ovf1, r_res_vld0, r_res_vld1;
    logic        w_rdy0, w_rdy1, w_mul_vld, w_mul_ovf, w_resp_done;
    logic [15:0] w_mul_res;

    multiplier_fpu u_mul (
        .i_a   (r_opa),
        .i_b   (r_opb),
        .i_vld (w_mul_vld),
        .o_res (w_mul_res),
        .o_ovf (w_mul_ovf)
    );

    assign w_resp_done    = (r_state == ST_RESP) && (r_owner ? bus.i_res_rdy1 : bus.i_res_rdy0);
    assign bus.o_rdy0     = w_rdy0;
    assign bus.o_rdy1     = w_rdy1;
    assign bus.o_res0     = r_res0;
    assign bus.o_res1     = r_res1;
    assign bus.o_ovf0     = r_ovf0;
    assign bus.o_ovf1     = r_ovf1;
    assign bus.o_res_vld0 = r_res_vld0;
    assign bus.o_res_vld1 = r_res_vld1;
    assign bus.o_busy     = (r_state != ST_IDLE);

    // Grant selection and next state; requests are only accepted in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        w_mul_vld   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rdy0 = bus.i_vld0 && (!bus.i_vld1 || !r_prio);
                w_rdy1 = bus.i_vld1 && (!bus.i_vld0 || r_prio);
                if (w_rdy0 || w_rdy1) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_mul_vld   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_resp_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, priority, owner and operand capture on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= L_PRIO_INIT;
            r_owner <= 1'b0;
            r_opa   <= 16'h0000;
            r_opb   <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_rdy0 || w_rdy1) begin
                r_opa   <= w_rdy1 ? bus.i_a1 : bus.i_a0;
                r_opb   <= w_rdy1 ? bus.i_b1 : bus.i_b0;
                r_owner <= w_rdy1;
                if (bus.i_vld0 && bus.i_vld1) begin
                    r_prio <= w_rdy0;
                end
            end
        end
    end

    // Result capture into the owner's outputs, cleared again by the response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res0     <= 16'h0000;
            r_res1     <= 16'h0000;
            r_ovf0     <= 1'b0;
            r_ovf1     <= 1'b0;
            r_res_vld0 <= 1'b0;
            r_res_vld1 <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            if (r_owner) begin
                r_res1     <= w_mul_res;
                r_ovf1     <= w_mul_ovf;
                r_res_vld1 <= 1'b1;
            end else begin
                r_res0     <= w_mul_res;
                r_ovf0     <= w_mul_ovf;
                r_res_vld0 <= 1'b1;
            end
        end else if (w_resp_done) begin
            r_res0     <= 16'h0000;
            r_res1     <= 16'h0000;
            r_ovf0     <= 1'b0;
            r_ovf1     <= 1'b0;
            r_res_vld0 <= 1'b0;
            r_res_vld1 <= 1'b0;
        end
    end

`ifdef FPU_MUL_STATS_EN
    localparam logic [STAT_W-1:0] L_CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] r_cnt0, r_cnt1;

    assign o_ovf_cnt0 = r_cnt0;
    assign o_ovf_cnt1 = r_cnt1;

    // Saturating overflow event counters, bumped when a flagged result is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= {STAT_W{1'b0}};
            r_cnt1 <= {STAT_W{1'b0}};
        end else if ((r_state == ST_EXEC) && w_mul_ovf) begin
            if (!r_owner && !(&r_cnt0)) begin
                r_cnt0 <= r_cnt0 + L_CNT_ONE;
            end
            if (r_owner && !(&r_cnt1)) begin
                r_cnt1 <= r_cnt1 + L_CNT_ONE;
            end
        end
    end
`endif
endmodule
